// File: rtl/dreimann_uart_tx.sv
// DreiMann dice reporter: on start, latches three dice and sends 'D', d0, d1, d2, '\n' over UART, LSB first.
// Default frame is 8N1. Defining DREIMANN_UART_PARITY_EN adds an even parity bit to each byte (8E1).
`timescale 1ns/1ps
module dreimann_uart_tx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic [2:0] die0,
  input  logic [2:0] die1,
  input  logic [2:0] die2,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  BIT_LAST  = 3'd7;
  localparam logic [2:0]  BYTE_LAST = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t          state_reg, state_next;
  logic [15:0]     baud_reg, baud_next;
  logic [2:0]      bit_reg, bit_next;
  logic [2:0]      byte_reg, byte_next;
  logic [2:0][2:0] dice_reg, dice_next;
  logic            tx_reg, tx_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            baud_done;
  logic [2:0][7:0] enc_next;
  logic [7:0]      byte_val_next;

  assign baud_done = (baud_reg == BAUD_LAST);

  // Dice 1..6 become ASCII digits; anything else is reported as '?'.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_enc
      assign enc_next[gi] = (dice_next[gi] >= 3'd1 && dice_next[gi] <= 3'd6)
                          ? (8'h30 + {5'd0, dice_next[gi]})
                          : 8'h3F;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    byte_next  = byte_reg;
    dice_next  = dice_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = START;
          baud_next  = '0;
          bit_next   = '0;
          byte_next  = '0;
          dice_next  = {die2, die1, die0};
        end
      end
      START: begin
        if (baud_done) begin
          state_next = DATA;
          baud_next  = '0;
          bit_next   = '0;
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_next = '0;
          if (bit_reg == BIT_LAST) begin
            bit_next = '0;
`ifdef DREIMANN_UART_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_next = bit_reg + 3'd1;
          end
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end
      PARITY: begin
        if (baud_done) begin
          state_next = STOP;
          baud_next  = '0;
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_next = '0;
          if (byte_reg == BYTE_LAST) begin
            state_next = DONE;
            byte_next  = '0;
          end else begin
            state_next = START;
            byte_next  = byte_reg + 3'd1;
          end
        end else begin
          baud_next = baud_reg + 16'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Dropping ena abandons the frame outright, without a done pulse.
    if (!ena) begin
      state_next = IDLE;
      baud_next  = '0;
      bit_next   = '0;
      byte_next  = '0;
    end
  end

  always_comb begin
    byte_val_next = 8'h0A;
    case (byte_next)
      3'd0:    byte_val_next = 8'h44;
      3'd1:    byte_val_next = enc_next[0];
      3'd2:    byte_val_next = enc_next[1];
      3'd3:    byte_val_next = enc_next[2];
      default: byte_val_next = 8'h0A;
    endcase
  end

  // Outputs are decoded from the upcoming state so tx/busy/done come straight off flops.
  always_comb begin
    tx_next   = 1'b1;
    busy_next = 1'b0;
    done_next = 1'b0;
    case (state_next)
      START: begin
        tx_next   = 1'b0;
        busy_next = 1'b1;
      end
      DATA: begin
        tx_next   = byte_val_next[bit_next];
        busy_next = 1'b1;
      end
      PARITY: begin
        tx_next   = ^byte_val_next;
        busy_next = 1'b1;
      end
      STOP:    busy_next = 1'b1;
      DONE:    done_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      byte_reg  <= '0;
      dice_reg  <= '0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      byte_reg  <= byte_next;
      dice_reg  <= dice_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign tx   = tx_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_dreimann_uart_tx.sv
// Self-checking bench for dreimann_uart_tx at CLKS_PER_BIT=4: table vectors, random dice, handshake corner cases.
`timescale 1ns/1ps
module tb_dreimann_uart_tx;

  localparam int C = 4;
`ifdef DREIMANN_UART_PARITY_EN
  localparam int BPB = 11;
`else
  localparam int BPB = 10;
`endif
  localparam int LEN    = 5 * BPB * C;
  localparam int MAXCAP = 2 * LEN + 40;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena   = 1'b0;
  logic       start = 1'b0;
  logic [2:0] die0  = 3'd0;
  logic [2:0] die1  = 3'd0;
  logic [2:0] die2  = 3'd0;
  logic       tx, busy, done;

  int tests = 0;
  int fails = 0;

  logic tx_s   [0:MAXCAP];
  logic busy_s [0:MAXCAP];
  logic done_s [0:MAXCAP];

  typedef struct {
    logic [2:0]      d0, d1, d2;
    logic [4:0][7:0] exp;
  } vec_t;
  vec_t vecs [4];

  dreimann_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .start (start),
    .die0  (die0),
    .die1  (die1),
    .die2  (die2),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: ASCII digit for 1..6, '?' otherwise; fixed header and trailer.
  function automatic logic [7:0] enc(input logic [2:0] v);
    if (v >= 3'd1 && v <= 3'd6) return 8'h30 + {5'd0, v};
    return 8'h3F;
  endfunction

  function automatic logic [4:0][7:0] frame_bytes(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    logic [4:0][7:0] f;
    f[0] = 8'h44;
    f[1] = enc(a);
    f[2] = enc(b);
    f[3] = enc(c);
    f[4] = 8'h0A;
    return f;
  endfunction

  // Expected line level `off` cycles into a frame: start 0, data LSB first, optional parity, stop 1.
  function automatic logic exp_bit(input logic [4:0][7:0] fb, input int off);
    int b, i, pos;
    b   = off / C;
    i   = b / BPB;
    pos = b % BPB;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return fb[i][pos-1];
    if (BPB == 11 && pos == 9) return ^fb[i];
    return 1'b1;
  endfunction

  task automatic begin_frame(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    @(negedge clk);
    die0  = a;
    die1  = b;
    die2  = c;
    start = 1'b1;
  endtask

  // Sample k = cycles after the accept edge; drive after sampling on the same falling edge.
  task automatic capture(input int n, input int hold_until, input int pulse_at,
                         input int ena_low_at, input int rst_at, input bit change_dice);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      tx_s[k]   = tx;
      busy_s[k] = busy;
      done_s[k] = done;
      if (k == hold_until) start = 1'b0;
      if (k == pulse_at) start = 1'b1;
      if (pulse_at > 0 && k == pulse_at + 1) start = 1'b0;
      if (k == ena_low_at) ena = 1'b0;
      if (ena_low_at > 0 && k == ena_low_at + 1) ena = 1'b1;
      if (change_dice && k == 3) begin
        die0 = ~die0;
        die1 = ~die1;
        die2 = ~die2;
      end
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        check("async_rst_tx", {31'd0, tx}, 32'd1);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
      end
      if (rst_at > 0 && k == rst_at + 2) rst_n = 1'b1;
    end
  endtask

  task automatic check_frame(input string name, input logic [4:0][7:0] fb, input int base);
    int mm, bcnt, dcnt;
    logic [7:0] got;
    logic [4:0][7:0] seen;
    mm   = 0;
    bcnt = 0;
    dcnt = 0;
    for (int k = 0; k < LEN; k++) begin
      if (tx_s[base+k] !== exp_bit(fb, k)) mm++;
      if (busy_s[base+k] === 1'b1) bcnt++;
      if (done_s[base+k] !== 1'b0) dcnt++;
    end
    check({name, "_tx_wave_errs"}, mm, 0);
    check({name, "_busy_cycles"}, bcnt, LEN);
    check({name, "_done_early"}, dcnt, 0);
    check({name, "_done_pulse"}, {31'd0, done_s[base+LEN]}, 32'd1);
    check({name, "_busy_at_done"}, {31'd0, busy_s[base+LEN]}, 32'd0);
    check({name, "_tx_at_done"}, {31'd0, tx_s[base+LEN]}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 8; j++) got[j] = tx_s[base + (i*BPB + 1 + j)*C + C/2];
      seen[i] = got;
      check($sformatf("%s_byte%0d", name, i), {24'd0, got}, {24'd0, fb[i]});
    end
    $display("[TB] %s: decoded %02h %02h %02h %02h %02h", name, seen[0], seen[1], seen[2], seen[3], seen[4]);
  endtask

  initial begin
    int cnt;
    logic [2:0] a, b, c;

    vecs[0].d0 = 3'd3; vecs[0].d1 = 3'd5; vecs[0].d2 = 3'd1; vecs[0].exp = {8'h0A, 8'h31, 8'h35, 8'h33, 8'h44};
    vecs[1].d0 = 3'd0; vecs[1].d1 = 3'd7; vecs[1].d2 = 3'd6; vecs[1].exp = {8'h0A, 8'h36, 8'h3F, 8'h3F, 8'h44};
    vecs[2].d0 = 3'd1; vecs[2].d1 = 3'd2; vecs[2].d2 = 3'd4; vecs[2].exp = {8'h0A, 8'h34, 8'h32, 8'h31, 8'h44};
    vecs[3].d0 = 3'd6; vecs[3].d1 = 3'd6; vecs[3].d2 = 3'd0; vecs[3].exp = {8'h0A, 8'h3F, 8'h36, 8'h36, 8'h44};

    // Reset held for three cycles, then released.
    ena = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_tx", {31'd0, tx}, 32'd1);
      check("post_rst_busy", {31'd0, busy}, 32'd0);
    end

    // Table vectors; the first also scrambles the dice mid-frame to prove they were latched.
    for (int v = 0; v < 4; v++) begin
      begin_frame(vecs[v].d0, vecs[v].d1, vecs[v].d2);
      capture(LEN + 4, 1, 0, 0, 0, v == 0);
      check_frame($sformatf("vec%0d", v), vecs[v].exp, 1);
    end

    for (int r = 0; r < 6; r++) begin
      a = 3'($urandom_range(0, 7));
      b = 3'($urandom_range(0, 7));
      c = 3'($urandom_range(0, 7));
      begin_frame(a, b, c);
      capture(LEN + 4, 1, 0, 0, 0, 1'b0);
      check_frame($sformatf("rnd%0d_%0d%0d%0d", r, a, b, c), frame_bytes(a, b, c), 1);
    end

    // Second start pulse in the middle of byte 2 must be dropped.
    begin_frame(3'd2, 3'd4, 3'd6);
    capture(LEN + 20, 1, 1 + 2*BPB*C + 6, 0, 0, 1'b0);
    check_frame("busy_start", frame_bytes(3'd2, 3'd4, 3'd6), 1);
    cnt = 0;
    for (int k = LEN + 1; k <= LEN + 20; k++) if (busy_s[k] !== 1'b0) cnt++;
    check("busy_start_no_refire", cnt, 0);
    cnt = 0;
    for (int k = 1; k <= LEN + 20; k++) if (done_s[k] === 1'b1) cnt++;
    check("busy_start_done_count", cnt, 1);

    // Start held: frames back to back with DONE + IDLE cycles between them.
    begin_frame(3'd3, 3'd5, 3'd1);
    capture(2*LEN + 10, LEN + 3, 0, 0, 0, 1'b0);
    check_frame("held_f1", frame_bytes(3'd3, 3'd5, 3'd1), 1);
    check("held_gap_tx", {31'd0, tx_s[LEN+2]}, 32'd1);
    check("held_gap_busy", {31'd0, busy_s[LEN+2]}, 32'd0);
    check("held_gap_done", {31'd0, done_s[LEN+2]}, 32'd0);
    check_frame("held_f2", frame_bytes(3'd3, 3'd5, 3'd1), LEN + 3);

    // ena dropped during byte 1 data bits.
    begin_frame(3'd3, 3'd5, 3'd1);
    capture(LEN + 10, 1, 0, 1 + BPB*C + C + 5, 0, 1'b0);
    check("abort_tx", {31'd0, tx_s[1 + BPB*C + C + 6]}, 32'd1);
    check("abort_busy", {31'd0, busy_s[1 + BPB*C + C + 6]}, 32'd0);
    cnt = 0;
    for (int k = 1; k <= LEN + 10; k++) if (done_s[k] === 1'b1) cnt++;
    check("abort_no_done", cnt, 0);
    cnt = 0;
    for (int k = 1 + BPB*C + C + 6; k <= LEN + 10; k++) if (busy_s[k] !== 1'b0) cnt++;
    check("abort_stays_idle", cnt, 0);
    begin_frame(vecs[0].d0, vecs[0].d1, vecs[0].d2);
    capture(LEN + 4, 1, 0, 0, 0, 1'b0);
    check_frame("after_abort", vecs[0].exp, 1);

    // Reset pulse mid-frame.
    begin_frame(3'd6, 3'd1, 3'd3);
    capture(LEN + 10, 1, 0, 0, 60, 1'b0);
    cnt = 0;
    for (int k = 1; k <= LEN + 10; k++) if (done_s[k] === 1'b1) cnt++;
    check("rst_mid_no_done", cnt, 0);
    cnt = 0;
    for (int k = 61; k <= LEN + 10; k++) if (busy_s[k] !== 1'b0 || tx_s[k] !== 1'b1) cnt++;
    check("rst_mid_idle", cnt, 0);
    begin_frame(vecs[1].d0, vecs[1].d1, vecs[1].d2);
    capture(LEN + 4, 1, 0, 0, 0, 1'b0);
    check_frame("after_rst", vecs[1].exp, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
